seg_capture: RTL and testbench

Recovers hex digits from a multiplexed, active-low seven-segment display bus: the inverse of the project's hex-to-segment decoder. It watches the segment and anode lines that drive the board display, waits until each lit pattern is stable, and maps it back to a nibble plus decimal point. It keeps one register per digit and flags patterns that are not legal hex glyphs. It sits beside the display driver as a self-check and readback path for the Project 2 display logic.

---
 rtl/seg_capture.sv | 164 ++++++++++++++++
 tb/tb_seg_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// Seven-segment readback: recovers per-digit hex nibbles and decimal points from a
// multiplexed active-low segment/anode bus once each lit pattern has been stable long enough.
module seg_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     err,
    output logic                  update,
    output logic [IW-1:0]         upd_idx,
    output logic                  frame
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int NW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    state_t              state, state_n;
    logic [7:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    logic [DIGITS+7:0]   prev_q;
    logic [CW-1:0]       cnt, cnt_n;
    logic [NW-1:0]       nzero;
    logic                sel_ok;
    logic [IW-1:0]       sel_idx;
    logic                changed;
    logic                capture;
    logic                glyph_ok;
    logic [3:0]          glyph;
    logic [DIGITS-1:0]   mask, mask_n;

    always_comb begin
        nzero   = '0;
        sel_idx = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) begin
                nzero   = nzero + 1'b1;
                sel_idx = IW'(i);
            end
        end
        sel_ok  = (nzero == NW'(1));
        changed = ({an_q, seg_q} != prev_q);
    end

    always_comb begin
        glyph_ok = 1'b1;
        glyph    = 4'h0;
        case (seg_q[6:0])
            7'b1000000: glyph = 4'h0;
            7'b1111001: glyph = 4'h1;
            7'b0100100: glyph = 4'h2;
            7'b0110000: glyph = 4'h3;
            7'b0011001: glyph = 4'h4;
            7'b0010010: glyph = 4'h5;
            7'b0000010: glyph = 4'h6;
            7'b1111000: glyph = 4'h7;
            7'b0000000: glyph = 4'h8;
            7'b0011000: glyph = 4'h9;
            7'b0001000: glyph = 4'hA;
            7'b0000011: glyph = 4'hB;
            7'b1000110: glyph = 4'hC;
            7'b0100001: glyph = 4'hD;
            7'b0000110: glyph = 4'hE;
            7'b0001110: glyph = 4'hF;
            default:    glyph_ok = 1'b0;
        endcase
    end

    // cnt counts samples of the current pattern; the capture decision is made while
    // the (STABLE_CYCLES-1)th sample is held so the result registers on the Nth edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        if (!sel_ok) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (changed || state == IDLE) begin
            state_n = COUNT;
            cnt_n   = CW'(1);
        end else begin
            case (state)
                COUNT: begin
                    if (cnt == CW'(STABLE_CYCLES - 1)) begin
                        capture = 1'b1;
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HOLD:    state_n = HOLD;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        mask_n = mask | (DIGITS'(1) << sel_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q  <= 8'hFF;
            an_q   <= '1;
            prev_q <= '1;
            state  <= IDLE;
            cnt    <= '0;
        end else begin
            seg_q  <= seg;
            an_q   <= an;
            prev_q <= {an_q, seg_q};
            state  <= state_n;
            cnt    <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value   <= '0;
            dp      <= '0;
            valid   <= '0;
            err     <= '0;
            update  <= 1'b0;
            upd_idx <= '0;
            frame   <= 1'b0;
            mask    <= '0;
        end else begin
            update <= capture;
            frame  <= 1'b0;
            if (capture) begin
                upd_idx     <= sel_idx;
                dp[sel_idx] <= ~seg_q[7];
                if (glyph_ok) begin
                    value[{sel_idx, 2'b00} +: 4] <= glyph;
                    valid[sel_idx]               <= 1'b1;
                    err[sel_idx]                 <= 1'b0;
                end else begin
                    valid[sel_idx] <= 1'b0;
                    err[sel_idx]   <= 1'b1;
                end
                if (mask_n == '1) begin
                    frame <= 1'b1;
                    mask  <= '0;
                end else begin
                    mask <= mask_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Randomized bench for seg_capture: a run-length reference model predicts every output each cycle.
module tb_seg_capture;

    localparam int D = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    seg = 8'hFF;
    logic [D-1:0]  an = '1;
    logic [4*D-1:0] value;
    logic [D-1:0]  dp, valid, err;
    logic          update, frame;
    logic [1:0]    upd_idx;

    seg_capture #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .seg(seg), .an(an),
        .value(value), .dp(dp), .valid(valid), .err(err),
        .update(update), .upd_idx(upd_idx), .frame(frame)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    logic [6:0] glyphs [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (glyphs[i] == p) return i;
        return -1;
    endfunction

    function automatic int which_digit(input logic [D-1:0] a);
        int n = 0;
        int k = -1;
        for (int i = 0; i < D; i++) if (!a[i]) begin n++; k = i; end
        return (n == 1) ? k : -1;
    endfunction

    // reference model: a pattern is captured once, when it has been sampled S times in a row
    logic [4*D-1:0] m_value = '0;
    logic [D-1:0]   m_dp = '0, m_valid = '0, m_err = '0, m_mask = '0;
    logic           m_update = 1'b0, m_frame = 1'b0;
    logic [1:0]     m_idx = '0;
    logic [D+7:0]   run_val = '1;
    int             run_len = 0;
    int             mk, mg;

    always @(posedge clk) begin
        if (reset) begin
            m_value = '0; m_dp = '0; m_valid = '0; m_err = '0; m_mask = '0;
            m_update = 1'b0; m_frame = 1'b0; m_idx = '0;
            run_val = '1; run_len = 0;
        end else begin
            m_update = 1'b0;
            m_frame  = 1'b0;
            mk = which_digit(run_val[D+7:8]);
            if (run_len == S && mk >= 0) begin
                mg = decode(run_val[6:0]);
                m_update  = 1'b1;
                m_idx     = mk[1:0];
                m_dp[mk]  = ~run_val[7];
                if (mg >= 0) begin
                    m_value[mk*4 +: 4] = mg[3:0];
                    m_valid[mk] = 1'b1;
                    m_err[mk]   = 1'b0;
                end else begin
                    m_valid[mk] = 1'b0;
                    m_err[mk]   = 1'b1;
                end
                m_mask[mk] = 1'b1;
                if (m_mask == '1) begin
                    m_frame = 1'b1;
                    m_mask  = '0;
                end
            end
            if ({an, seg} == run_val) begin
                if (run_len <= S) run_len++;
            end else begin
                run_val = {an, seg};
                run_len = 1;
            end
        end
    end

    logic chk_on = 1'b0;
    int   n_upd = 0, n_frm = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("update", 64'(update), 64'(m_update));
            check("frame", 64'(frame), 64'(m_frame));
            check("upd_idx", 64'(upd_idx), 64'(m_idx));
            check("value", 64'(value), 64'(m_value));
            check("dp", 64'(dp), 64'(m_dp));
            check("valid", 64'(valid), 64'(m_valid));
            check("err", 64'(err), 64'(m_err));
            if (update) n_upd++;
            if (frame) n_frm++;
        end
    end

    task automatic apply(input logic [D-1:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    int u0, f0, lat;
    logic [D-1:0] ra;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        check("rst_value", 64'(value), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        reset = 1'b0;

        // single digit 0
        u0 = n_upd;
        apply(4'b1110, 8'hC0, 10);
        check("t1_nupd", 64'(n_upd - u0), 64'(1));
        check("t1_nib", 64'(value[3:0]), 64'(0));
        check("t1_valid", 64'(valid), 64'(4'b0001));
        check("t1_nfrm", 64'(n_frm), 64'(0));

        // full scan
        f0 = n_frm;
        apply(4'b1110, 8'hA4, 6);
        apply(4'b1101, 8'h30, 6);
        apply(4'b1011, 8'h88, 6);
        apply(4'b0111, 8'h0E, 6);
        check("scan_value", 64'(value), 64'(16'hFA32));
        check("scan_valid", 64'(valid), 64'(4'hF));
        check("scan_dp", 64'(dp), 64'(4'b1010));
        check("scan_nfrm", 64'(n_frm - f0), 64'(1));

        // blank pattern on digit 1 after a 5
        apply(4'b1101, 8'h92, 5);
        apply(4'b1101, 8'hFF, 6);
        check("blank_err", 64'(err), 64'(4'b0010));
        check("blank_valid1", 64'(valid[1]), 64'(0));
        check("blank_val1", 64'(value[7:4]), 64'(5));

        // illegal select and short glitch between stable windows
        u0 = n_upd;
        apply(4'b1011, 8'hF9, 6);
        apply(4'b1100, 8'hF9, 3);
        apply(4'b1011, 8'hF9, 6);
        check("illegal_nupd", 64'(n_upd - u0), 64'(2));
        u0 = n_upd;
        apply(4'b1011, 8'hA4, 3);
        apply(4'b1011, 8'hF9, 6);
        check("glitch_nupd", 64'(n_upd - u0), 64'(1));

        // reset in the middle of a window
        apply(4'b1110, 8'hF9, 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_value", 64'(value), 64'(0));
        check("mid_rst_upd", 64'(update), 64'(0));
        reset = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (update) begin lat = i; break; end
        end
        check("rst_latency", 64'(lat), 64'(S + 1));

        // random traffic
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 99) < 85) begin
                ra = '1;
                ra[$urandom_range(0, D - 1)] = 1'b0;
            end else begin
                ra = D'($urandom);
            end
            if ($urandom_range(0, 99) < 3) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b0;
            end
            if ($urandom_range(0, 99) < 70)
                apply(ra, {1'($urandom), glyphs[$urandom_range(0, 15)]}, $urandom_range(1, 7));
            else
                apply(ra, 8'($urandom), $urandom_range(1, 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
